// File: rtl/switch_debouncer8.sv
// Two-flop synchroniser plus independent per-bit debounce for eight slide switches.
// Emits registered clean levels, a one-cycle change strobe and a sticky post-reset READY flag.
module switch_debouncer8 #(
    parameter int CNT_MAX = 1000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SW_IN,
    output logic [7:0] SW_OUT,
    output logic       CHANGED,
    output logic       READY
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int SET_W = $clog2(CNT_MAX + 3);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(CNT_MAX + 1);

    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       sw_out_q;
    logic [7:0]       sw_out_d;
    logic             changed_q;
    logic             changed_d;
    logic             ready_q;
    logic             ready_d;
    logic [SET_W-1:0] settle_q;
    logic [SET_W-1:0] settle_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];

    // Per-bit debounce: any cycle where the synchronised level agrees with the output restarts the count
    always_comb begin
        sw_out_d = sw_out_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == sw_out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                sw_out_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        changed_d = (sw_out_d != sw_out_q);
    end

    // Settle window: counter freezes once READY is set, so it cannot wrap
    always_comb begin
        settle_d = settle_q;
        ready_d  = ready_q;
        if (!ready_q) begin
            settle_d = settle_q + SET_W'(1);
            if (settle_q == SET_LAST) begin
                ready_d = 1'b1;
            end else begin
                ready_d = 1'b0;
            end
        end else begin
            settle_d = settle_q;
            ready_d  = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q   <= 8'h00;
            sync2_q   <= 8'h00;
            sw_out_q  <= 8'h00;
            changed_q <= 1'b0;
            ready_q   <= 1'b0;
            settle_q  <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= SW_IN;
            sync2_q   <= sync1_q;
            sw_out_q  <= sw_out_d;
            changed_q <= changed_d;
            ready_q   <= ready_d;
            settle_q  <= settle_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign SW_OUT  = sw_out_q;
    assign CHANGED = changed_q;
    assign READY   = ready_q;

endmodule

// File: tb/tb_switch_debouncer8.sv
// Bench for switch_debouncer8 (CNT_MAX=4): directed table, corner sequences and
// randomised stimulus against a run-length reference model.
module tb_switch_debouncer8;

    localparam int CNT_MAX = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] SW_IN;
    logic [7:0] SW_OUT;
    logic       CHANGED;
    logic       READY;

    int n_tests = 0;
    int n_fail  = 0;

    switch_debouncer8 #(.CNT_MAX(CNT_MAX)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .SW_IN   (SW_IN),
        .SW_OUT  (SW_OUT),
        .CHANGED (CHANGED),
        .READY   (READY)
    );

    always #5 CLK = ~CLK;

    // Reference model: raw samples delayed two edges, output bit flips after
    // CNT_MAX consecutive edges of disagreement.
    logic [7:0] hist [$];
    int         run [8];
    logic [7:0] m_out;
    logic       m_chg;
    logic       m_rdy;
    int         m_edges;

    task automatic model_edge(input logic [7:0] sw, input logic rst);
        logic [7:0] s;
        logic [7:0] nxt;
        if (rst) begin
            hist.delete();
            for (int i = 0; i < 8; i++) run[i] = 0;
            m_out   = 8'h00;
            m_chg   = 1'b0;
            m_rdy   = 1'b0;
            m_edges = 0;
        end else begin
            s = (hist.size() >= 2) ? hist[hist.size() - 2] : 8'h00;
            hist.push_back(sw);
            if (hist.size() > 4) void'(hist.pop_front());
            nxt = m_out;
            for (int i = 0; i < 8; i++) begin
                if (s[i] != m_out[i]) begin
                    run[i]++;
                    if (run[i] == CNT_MAX) begin
                        nxt[i] = s[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            m_chg = (nxt != m_out);
            m_out = nxt;
            if (m_edges < CNT_MAX + 2) m_edges++;
            m_rdy = (m_edges >= CNT_MAX + 2);
        end
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [7:0] sw, input logic rst);
        SW_IN = sw;
        RST   = rst;
        @(posedge CLK);
        model_edge(sw, rst);
        #1;
        check("model_out", SW_OUT, m_out);
        check("model_changed", {7'h0, CHANGED}, {7'h0, m_chg});
        check("model_ready", {7'h0, READY}, {7'h0, m_rdy});
    endtask

    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    typedef struct {
        logic [7:0] sw;
        logic       rst;
        logic [7:0] out;
        logic       chg;
        logic       rdy;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input logic [7:0] sw, input logic rst,
                                input logic [7:0] out, input logic chg, input logic rdy);
        vec_t v;
        v.sw = sw; v.rst = rst; v.out = out; v.chg = chg; v.rdy = rdy;
        tbl.push_back(v);
    endfunction

    int         pulses;
    logic [7:0] cur;
    int         b;

    initial begin
        SW_IN = 8'h00;
        RST   = 1'b1;

        // Reset, idle to READY, then a single step on bit 3
        add(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        add(8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int e = 1; e <= 5; e++) add(8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        add(8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int e = 1; e <= 5; e++) add(8'h08, 1'b0, 8'h00, 1'b0, 1'b1);
        add(8'h08, 1'b0, 8'h08, 1'b1, 1'b1);
        add(8'h08, 1'b0, 8'h08, 1'b0, 1'b1);
        add(8'h08, 1'b0, 8'h08, 1'b0, 1'b1);

        for (int k = 0; k < tbl.size(); k++) begin
            cycle(tbl[k].sw, tbl[k].rst);
            check("tbl_out", SW_OUT, tbl[k].out);
            check("tbl_changed", {7'h0, CHANGED}, {7'h0, tbl[k].chg});
            check("tbl_ready", {7'h0, READY}, {7'h0, tbl[k].rdy});
        end
        check("encoder_code", {5'h0, enc8(SW_OUT)}, 8'h03);

        // Bounce on bit 0 then hold high
        pulses = 0;
        cycle(8'h09, 1'b0); if (CHANGED) pulses++;
        cycle(8'h08, 1'b0); if (CHANGED) pulses++;
        cycle(8'h09, 1'b0); if (CHANGED) pulses++;
        cycle(8'h08, 1'b0); if (CHANGED) pulses++;
        check("bounce_hold", SW_OUT, 8'h08);
        for (int j = 1; j <= 8; j++) begin
            cycle(8'h09, 1'b0);
            if (CHANGED) pulses++;
            if (j == 5) check("bounce_edge5", SW_OUT, 8'h08);
            if (j == 6) begin
                check("bounce_edge6", SW_OUT, 8'h09);
                check("bounce_chg6", {7'h0, CHANGED}, 8'h01);
            end
        end
        check("bounce_pulses", 8'(pulses), 8'h01);

        // Two bits completing on the same edge
        for (int j = 0; j < 2; j++) cycle(8'h00, 1'b1);
        for (int j = 0; j < 8; j++) cycle(8'h00, 1'b0);
        pulses = 0;
        for (int j = 1; j <= 8; j++) begin
            cycle(8'h81, 1'b0);
            if (CHANGED) pulses++;
            if (j == 5) check("multi_edge5", SW_OUT, 8'h00);
            if (j == 6) check("multi_edge6", SW_OUT, 8'h81);
        end
        check("multi_pulses", 8'(pulses), 8'h01);

        // Switches high through reset release
        for (int j = 0; j < 2; j++) cycle(8'hFF, 1'b1);
        for (int j = 1; j <= 7; j++) begin
            cycle(8'hFF, 1'b0);
            if (j == 5) begin
                check("ff_edge5_out", SW_OUT, 8'h00);
                check("ff_edge5_rdy", {7'h0, READY}, 8'h00);
            end
            if (j == 6) begin
                check("ff_edge6_out", SW_OUT, 8'hFF);
                check("ff_edge6_chg", {7'h0, CHANGED}, 8'h01);
                check("ff_edge6_rdy", {7'h0, READY}, 8'h01);
            end
        end

        // Reset while bit 4 is mid-count
        for (int j = 0; j < 2; j++) cycle(8'h00, 1'b1);
        for (int j = 0; j < 8; j++) cycle(8'h00, 1'b0);
        for (int j = 0; j < 4; j++) cycle(8'h10, 1'b0);
        cycle(8'h10, 1'b1);
        check("midrst_out", SW_OUT, 8'h00);
        check("midrst_rdy", {7'h0, READY}, 8'h00);
        check("midrst_chg", {7'h0, CHANGED}, 8'h00);
        for (int j = 1; j <= 6; j++) begin
            cycle(8'h10, 1'b0);
            if (j == 5) check("midrst_edge5", SW_OUT, 8'h00);
            if (j == 6) check("midrst_edge6", SW_OUT, 8'h10);
        end

        // Randomised activity with bounces and occasional resets
        cur = 8'h10;
        for (int k = 0; k < 3000; k++) begin
            b = int'($urandom_range(0, 15));
            if (b == 0) begin
                cur = 8'($urandom);
            end else if (b < 4) begin
                b = int'($urandom_range(0, 7));
                cur[b] = ~cur[b];
            end
            cycle(cur, ($urandom_range(0, 399) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_debouncer8.md
Name: switch_debouncer8

Overview:
Upstream conditioning stage for the 8-to-3 switch encoder. It synchronises the eight raw board slide switches to CLK and debounces each one independently. It presents clean, glitch-free levels on SW_OUT[7:0], which drive the encoder's SW0..SW7 inputs. It also flags each change of the debounced value so downstream logic can react once per real switch movement.

Parameters:
CNT_MAX, 1000000, number of consecutive CLK cycles a synchronised input must differ from the debounced value before it is accepted (10 ms at 100 MHz); legal range >= 2
CNT_W, $clog2(CNT_MAX+1), width of the per-bit counters; derived, not overridden

Ports:
CLK  input  1  system clock; all logic on the rising edge
RST  input  1  synchronous, active-high reset
SW_IN  input  8  raw asynchronous switch levels, bit i = switch i
SW_OUT  output  8  debounced switch levels, bit i feeds encoder input SWi
CHANGED  output  1  one-cycle pulse, high in the cycle SW_OUT takes a new value
READY  output  1  high once the post-reset settle window has elapsed; sticky until next reset

Behaviour:
- Everything is synchronous to CLK. RST is sampled only on rising edges.
- Reset values:
  - sync stage 1 and stage 2 = 0
  - all eight counters = 0
  - SW_OUT = 8'h00
  - CHANGED = 0
  - READY = 0
  - settle counter = 0
- Synchroniser: two flops per bit. sync2[i] is the only version of SW_IN[i] used by the debounce logic.
- Per-bit debounce, evaluated each edge:
  - if sync2[i] == SW_OUT[i]: cnt[i] <= 0
  - else if cnt[i] == CNT_MAX-1: SW_OUT[i] <= sync2[i], cnt[i] <= 0
  - else: cnt[i] <= cnt[i]+1
- Any single-cycle return of sync2[i] to SW_OUT[i] restarts that bit's count from 0. Bounce never produces an output toggle.
- Latency: a clean SW_IN[i] step appears on SW_OUT[i] exactly CNT_MAX+2 rising edges after the change. Edge 1 is the first edge that samples the new level.
- Bits are fully independent:
  - several bits completing on the same edge all update on that edge
  - that edge produces a single CHANGED pulse
- CHANGED:
  - registered, = (next SW_OUT != current SW_OUT)
  - high for exactly one cycle, coincident with the new SW_OUT value
  - back-to-back accepted changes on different bits produce back-to-back pulses
- READY:
  - the settle counter increments every cycle after reset
  - READY rises on the edge the count reaches CNT_MAX+2, then stays high and the counter holds
  - SW_OUT is valid downstream only while READY = 1; the encoder stage may ignore SW_OUT before then
- Switches already high at reset release are treated as ordinary changes: they propagate after CNT_MAX+2 edges with a CHANGED pulse, on the same edge READY rises.
- Reset mid-operation:
  - all state returns to reset values on that edge, regardless of counters in progress
  - no CHANGED pulse is generated by reset itself
- Counter saturation: cnt[i] never exceeds CNT_MAX-1, so no wrap-around is possible.
- No combinational path from SW_IN to any output.

Test Plan:
(All scenarios use CNT_MAX=4.)
1. Reset, SW_IN=8'h00 held -> SW_OUT=8'h00 and CHANGED=0 throughout; READY=1 from edge 6 after RST release.
2. After READY, step SW_IN=8'h08 and hold -> SW_OUT=8'h08 at edge 6 after the change; CHANGED high exactly that one cycle; encoder downstream reads 3'b011.
3. SW_IN[0] toggles 1,0,1,0,1 on consecutive cycles, then holds 1 -> no SW_OUT change during the toggling; SW_OUT[0]=1 exactly 6 edges after the final transition; one CHANGED pulse.
4. SW_IN steps from 8'h00 to 8'h81 in one cycle -> bits 7 and 0 update on the same edge (SW_OUT=8'h81); single CHANGED pulse.
5. SW_IN=8'hFF during reset, RST released -> SW_OUT=8'hFF, CHANGED=1 and READY=1 all on edge 6.
6. SW_IN=8'h10 with bit 4 at count 2, assert RST for one cycle -> SW_OUT=8'h00, READY=0, no CHANGED pulse; after release, SW_OUT=8'h10 at edge 6.
